// File: rtl/uart_echo_pkg.sv
// Shared types and the per-byte transform for the UART echo bridge.
// The transform works on one 8-bit character; wider data words carry extra bits alongside it.
package uart_echo_pkg;

    typedef enum logic [1:0] {
        MODE_ECHO   = 2'd0,
        MODE_UPPER  = 2'd1,
        MODE_INVERT = 2'd2,
        MODE_SINK   = 2'd3
    } mode_e;

    localparam logic [7:0] ASCII_LOWER_A    = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z    = 8'h7A;
    localparam logic [7:0] ASCII_CASE_DELTA = 8'h20;

    // SINK returns the byte unchanged; the caller is responsible for not enqueueing it.
    function automatic logic [7:0] transform(input logic [7:0] data, input mode_e mode);
        logic [7:0] result;
        result = data;
        case (mode)
            MODE_UPPER: begin
                if (data >= ASCII_LOWER_A && data <= ASCII_LOWER_Z) begin
                    result = data - ASCII_CASE_DELTA;
                end
            end
            MODE_INVERT: result = ~data;
            default:     result = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_echo_bridge_fifo.sv
// Synchronous FIFO with wrap-bit pointers, synchronous clear and occupancy output.
// Push while full and pop while empty are ignored; clear overrides both.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                     (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign empty_o = (wr_ptr == rd_ptr);
    assign level_o = wr_ptr - rd_ptr;
    assign rdata_o = mem[rd_ptr[ADDR_W-1:0]];

    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // NOTE: storage is deliberately not reset; empty pointers make stale contents invisible
    // and leaving it reset-free lets the array map onto plain RAM/flop arrays.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_echo_bridge.sv
// Byte-stream bridge: transforms received bytes, buffers them for the transmitter,
// latches LEDs from the raw byte and keeps saturating receive/overflow statistics. DATA_W >= 8.
module uart_echo_bridge
    import uart_echo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int LED_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [DATA_W-1:0]        rx_data_i,
    input  logic                     rx_valid_i,
    input  logic [1:0]               mode_i,
    input  logic                     clear_i,
    output logic [DATA_W-1:0]        tx_data_o,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    output logic [LED_W-1:0]         led_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CNT_W-1:0]         rx_count_o,
    output logic [CNT_W-1:0]         ovf_count_o,
    output logic                     ovf_o
);

    mode_e             mode;
    logic [DATA_W-1:0] xformed;
    logic              push_req;
    logic              fifo_full;
    logic              fifo_empty;
    logic              overflow;
    logic              pop;

    assign mode = mode_e'(mode_i);

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        xformed      = (mode == MODE_INVERT) ? ~rx_data_i : rx_data_i;
        xformed[7:0] = transform(rx_data_i[7:0], mode);
    end

    assign push_req   = rx_valid_i && !clear_i && (mode != MODE_SINK);
    assign overflow   = push_req && fifo_full;
    assign tx_valid_o = !fifo_empty;
    assign pop        = tx_valid_o && tx_ready_i;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push_req),
        .wdata_i (xformed),
        .pop_i   (pop),
        .rdata_o (tx_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    // Clear zeroes the statistics but keeps the LEDs showing the last byte seen.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            led_o       <= '0;
            rx_count_o  <= '0;
            ovf_count_o <= '0;
            ovf_o       <= 1'b0;
        end else if (clear_i) begin
            rx_count_o  <= '0;
            ovf_count_o <= '0;
            ovf_o       <= 1'b0;
        end else if (rx_valid_i) begin
            led_o <= rx_data_i[LED_W-1:0];
            if (rx_count_o != '1) rx_count_o <= rx_count_o + CNT_W'(1);
            if (overflow) begin
                ovf_o <= 1'b1;
                if (ovf_count_o != '1) ovf_count_o <= ovf_count_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/uart_echo_bridge.md
Name: uart_echo_bridge

Overview:
Parametrised byte-stream bridge between a UART receiver and transmitter. It buffers received bytes in a FIFO and applies a selectable per-byte transform. It replays the bytes to the transmitter under a valid/ready handshake, and latches the low bits of the last received byte onto status LEDs. It sits at top level between the uart core and the board pins, and adds buffering, backpressure, transform modes and statistics.

Parameters:
DATA_W, 8, byte width of rx/tx data
DEPTH, 16, FIFO entries; power of two, >= 2
LED_W, 3, number of LED outputs driven from last received byte (LED_W <= DATA_W)
CNT_W, 16, width of rx and overflow counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
rx_data_i  in  DATA_W  received byte, valid when rx_valid_i=1
rx_valid_i  in  1  single-cycle strobe: new byte received
mode_i  in  2  transform select, sampled on each accepted rx strobe
clear_i  in  1  synchronous flush of FIFO and counters
tx_data_o  out  DATA_W  head-of-FIFO byte
tx_valid_o  out  1  FIFO non-empty
tx_ready_i  in  1  transmitter accepts tx_data_o this cycle
led_o  out  LED_W  low LED_W bits of last raw received byte
level_o  out  $clog2(DEPTH)+1  current FIFO occupancy
rx_count_o  out  CNT_W  bytes received (all modes), saturating
ovf_count_o  out  CNT_W  bytes dropped due to full FIFO, saturating
ovf_o  out  1  sticky overflow flag

Behaviour:
- Reset is asynchronous and active-low on rst_ni, clocked on clk_i. All of these reset to 0: FIFO pointers, level_o, tx_valid_o, led_o, rx_count_o, ovf_count_o and ovf_o. tx_data_o is don't-care while tx_valid_o=0.
- Modes (mode_i):
  - 0 ECHO: byte unchanged.
  - 1 UPPER: if byte is in 8'h61..8'h7A, subtract 8'h20; otherwise unchanged. This applies to the low 8 bits only; upper bits pass unchanged.
  - 2 INVERT: bitwise NOT.
  - 3 SINK: byte is not enqueued.
- Transform is applied at enqueue time. Bytes already in the FIFO are unaffected by later mode_i changes.
- On every rx_valid_i=1 with clear_i=0:
  - rx_count_o increments, saturating at 2^CNT_W-1.
  - led_o <= rx_data_i[LED_W-1:0], using the raw byte regardless of mode.
- Push occurs when rx_valid_i=1, mode!=3 and the FIFO is not full. Fullness is evaluated from pre-cycle state.
- Push while full: the byte is dropped, ovf_count_o increments (saturating) and ovf_o is set. This holds even if a pop happens in the same cycle.
- Pop occurs when tx_valid_o && tx_ready_i. tx_ready_i is ignored while the FIFO is empty.
- tx_valid_o = (level != 0). tx_data_o shows the head entry combinationally from storage, stable until popped.
- Latency: a byte strobed at edge N appears on tx_valid_o/tx_data_o after edge N. There is no same-cycle bypass when empty.
- Simultaneous push and pop (FIFO not full, not empty): level_o is unchanged and both pointers advance.
- Pointers are ADDR_W+1 bits with wrap bit. full = addresses equal and wrap bits differ; empty = pointers equal. Wrap-around is transparent.
- level_o = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
- clear_i=1 takes priority over everything in the same cycle:
  - pointers, level_o, counters and ovf_o go to 0;
  - led_o holds its value;
  - a coincident rx strobe is discarded and not counted.
- Reset asserted mid-transfer empties the FIFO immediately; any in-flight tx byte is lost.

Decomposition:
- Package uart_echo_pkg:
  - mode_e enum (MODE_ECHO=2'd0, MODE_UPPER=2'd1, MODE_INVERT=2'd2, MODE_SINK=2'd3);
  - ASCII_LOWER_A=8'h61, ASCII_LOWER_Z=8'h7A, ASCII_CASE_DELTA=8'h20;
  - function transform(byte, mode).
- One sub-module, sync_fifo (params WIDTH, DEPTH), with push/pop/full/empty/level/clear.
- uart_echo_bridge contains the transform, counters, LED latch and overflow logic.

Test Plan:
- Reset, then ECHO: strobe 8'h41, 8'h42 with tx_ready_i=1 -> tx sequence 8'h41, 8'h42. led_o=3'b010 after the second strobe. rx_count_o=2, level_o returns to 0.
- UPPER mode: strobe 8'h61, 8'h7A, 8'h5B, 8'h7B -> tx 8'h41, 8'h5A, 8'h5B, 8'h7B. INVERT mode: 8'h0F -> 8'hF0.
- Backpressure and overflow: tx_ready_i=0, strobe 18 bytes 8'h00..8'h11 with DEPTH=16 -> level_o=16, ovf_count_o=2, ovf_o=1. Releasing ready drains exactly 8'h00..8'h0F in order.
- Simultaneous push/pop when full: level=16, rx strobe plus tx pop in the same cycle -> byte dropped, ovf_count_o+1, level_o=15 next cycle.
- SINK mode: strobe 5 bytes -> tx_valid_o stays 0, rx_count_o=5, led_o tracks the last byte.
- clear_i with rx strobe in the same cycle while level=7 -> level_o=0, counters=0, ovf_o=0, led_o unchanged. Then async rst_ni pulse mid-pop -> all outputs 0 immediately.
